wishbone_master: RTL and testbench

WISHBONE_MASTER -- requirements
Module: wishbone_master

---
 rtl/wishbone_master_pkg.sv | 35 +++
 rtl/wishbone_master_if.sv | 27 ++
 rtl/wishbone_master.sv | 160 ++++++++++++++++
 tb/tb_wishbone_master.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/wishbone_master_pkg.sv
// Shared Wishbone bus definitions: master FSM encoding, response codes,
// the latched request record and a counter-width helper.
package wishbone_master_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } wb_state_e;

  typedef enum logic [1:0] {
    RSP_OK  = 2'b00,  // acknowledged
    RSP_ERR = 2'b01,  // slave signalled err_i
    RSP_RTY = 2'b10,  // retry budget exhausted
    RSP_TMO = 2'b11   // no termination within the timeout window
  } rsp_code_e;

  // Host request captured on acceptance and replayed on every re-issue.
  typedef struct packed {
    logic        we;
    logic [31:0] adr;
    logic [3:0]  sel;
    logic [31:0] dat;
  } wb_req_t;

  // Width of a counter that must reach max_val, never narrower than 8 bits.
  function automatic int cnt_width(input int unsigned max_val);
    int w;
    w = $clog2(longint'(max_val) + 1);
    if (w < 8) w = 8;
    return w;
  endfunction

endpackage

// File: rtl/wishbone_master_if.sv
// Wishbone classic bus between one master and one slave; signal names keep
// the master's point of view so both sides share one vocabulary.
interface wishbone_master_if;

  logic        cyc_o;
  logic        stb_o;
  logic        we_o;
  logic [31:0] adr_o;
  logic [3:0]  sel_o;
  logic [31:0] dat_o;
  logic [31:0] dat_i;
  logic        ack_i;
  logic        err_i;
  logic        rty_i;
  logic        stall_i;

  modport master (
    output cyc_o, stb_o, we_o, adr_o, sel_o, dat_o,
    input  dat_i, ack_i, err_i, rty_i, stall_i
  );

  modport slave (
    input  cyc_o, stb_o, we_o, adr_o, sel_o, dat_o,
    output dat_i, ack_i, err_i, rty_i, stall_i
  );

endinterface

// File: rtl/wishbone_master.sv
// Single-outstanding Wishbone master: accepts one host request, issues it on
// the bus with stall/retry/timeout handling and returns a one-cycle response.
module wishbone_master
  import wishbone_master_pkg::*;
#(
  parameter int unsigned RETRY_MAX = 3,
  parameter int unsigned TIMEOUT   = 255
) (
  input  logic              clk_bus,
  input  logic              rst_bus,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [31:0]       req_adr,
  input  logic [3:0]        req_sel,
  input  logic [31:0]       req_dat,
  output logic              rsp_valid,
  output logic [31:0]       rsp_dat,
  output logic [1:0]        rsp_code,
  output logic              busy,
  wishbone_master_if.master wb
);

  localparam int RW = cnt_width(RETRY_MAX);
  localparam int TW = cnt_width(TIMEOUT);
  localparam logic [RW-1:0] RETRY_LIM = RW'(RETRY_MAX);
  localparam logic [TW-1:0] TMO_LIM   = TW'(TIMEOUT);

  wb_state_e     state_q, state_d;
  // Set for the single bus-idle cycle between a retried attempt and its
  // re-issue; the FSM sits in IDLE but refuses new host requests.
  logic          gap_q, gap_d;
  wb_req_t       req_q;
  logic [RW-1:0] rty_cnt_q;
  logic [TW-1:0] tmo_cnt_q;
  logic [TW-1:0] tmo_nxt;
  logic [31:0]   rsp_dat_q;
  rsp_code_e     rsp_code_q;

  // Decisions taken by the next-state logic and consumed by the datapath.
  logic          accept;
  logic          retry;
  logic          finish;
  logic          tmo_inc;
  rsp_code_e     fin_code;
  logic [31:0]   fin_dat;

  assign tmo_nxt = tmo_cnt_q + TW'(1);

  // State register: asynchronous reset returns to IDLE with no pending gap.
  always_ff @(posedge clk_bus or posedge rst_bus) begin
    if (rst_bus) begin
      state_q <= ST_IDLE;
      gap_q   <= 1'b0;
    end else begin
      // NOTE: registers use non-blocking assignment so every flop samples
      // pre-edge values regardless of process evaluation order.
      state_q <= state_d;
      gap_q   <= gap_d;
    end
  end

  // Next-state logic; terminations are looked at only in WAIT, err first.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves
    // it unassigned, which would otherwise infer a latch.
    state_d  = state_q;
    gap_d    = 1'b0;
    accept   = 1'b0;
    retry    = 1'b0;
    finish   = 1'b0;
    tmo_inc  = 1'b0;
    fin_code = RSP_OK;
    fin_dat  = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (gap_q) begin
          state_d = ST_REQ;
        end else if (req_valid) begin
          accept  = 1'b1;
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        if (!wb.stall_i) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (wb.err_i) begin
          finish   = 1'b1;
          fin_code = RSP_ERR;
        end else if (wb.rty_i) begin
          if (rty_cnt_q < RETRY_LIM) begin
            retry   = 1'b1;
            gap_d   = 1'b1;
            state_d = ST_IDLE;
          end else begin
            finish   = 1'b1;
            fin_code = RSP_RTY;
          end
        end else if (wb.ack_i) begin
          finish   = 1'b1;
          fin_code = RSP_OK;
          fin_dat  = req_q.we ? 32'h0 : wb.dat_i;
        end else if (tmo_nxt >= TMO_LIM) begin
          finish   = 1'b1;
          fin_code = RSP_TMO;
        end else begin
          tmo_inc = 1'b1;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
    endcase
    if (finish) state_d = ST_RESP;
  end

  // Datapath: latch the request, run the retry/timeout counters and hold the
  // last response until the next one completes.
  always_ff @(posedge clk_bus or posedge rst_bus) begin
    if (rst_bus) begin
      req_q      <= '0;
      rty_cnt_q  <= '0;
      tmo_cnt_q  <= '0;
      rsp_dat_q  <= '0;
      rsp_code_q <= RSP_OK;
    end else begin
      if (accept) begin
        req_q     <= '{we: req_we, adr: req_adr, sel: req_sel, dat: req_dat};
        rty_cnt_q <= '0;
        tmo_cnt_q <= '0;
      end
      if (retry) begin
        rty_cnt_q <= rty_cnt_q + RW'(1);
        tmo_cnt_q <= '0;
      end
      if (tmo_inc) tmo_cnt_q <= tmo_nxt;
      if (finish) begin
        rsp_dat_q  <= fin_dat;
        rsp_code_q <= fin_code;
      end
    end
  end

  // Outputs decoded from state; req_ready is also masked by reset itself.
  always_comb begin
    req_ready = (state_q == ST_IDLE) && !gap_q && !rst_bus;
    busy      = (state_q != ST_IDLE) || gap_q;
    rsp_valid = (state_q == ST_RESP);
    rsp_dat   = rsp_dat_q;
    rsp_code  = rsp_code_q;
    wb.cyc_o  = (state_q == ST_REQ) || (state_q == ST_WAIT);
    wb.stb_o  = (state_q == ST_REQ);
    wb.we_o   = req_q.we;
    wb.adr_o  = req_q.adr;
    wb.sel_o  = req_q.sel;
    wb.dat_o  = req_q.dat;
  end

endmodule

// File: tb/tb_wishbone_master.sv
// Bench for wishbone_master: a scripted slave answers each transfer while a
// scoreboard queue holds the response expected for every issued request.
module tb_wishbone_master;

  localparam int RMAX     = 3;
  localparam int TMO      = 255;
  localparam int T_ACK    = 0;
  localparam int T_ERR    = 1;
  localparam int T_ERRACK = 2;
  localparam int T_NONE   = 3;

  logic        clk_bus = 1'b0;
  logic        rst_bus;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_adr;
  logic [3:0]  req_sel;
  logic [31:0] req_dat;
  logic        rsp_valid;
  logic [31:0] rsp_dat;
  logic [1:0]  rsp_code;
  logic        busy;

  wishbone_master_if wb ();

  wishbone_master #(.RETRY_MAX(RMAX), .TIMEOUT(TMO)) dut (
    .clk_bus  (clk_bus),
    .rst_bus  (rst_bus),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_we   (req_we),
    .req_adr  (req_adr),
    .req_sel  (req_sel),
    .req_dat  (req_dat),
    .rsp_valid(rsp_valid),
    .rsp_dat  (rsp_dat),
    .rsp_code (rsp_code),
    .busy     (busy),
    .wb       (wb.master)
  );

  typedef struct {
    logic [31:0] dat;
    logic [1:0]  code;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc_n    = 0;

  always #5 clk_bus = ~clk_bus;
  always @(posedge clk_bus) cyc_n <= cyc_n + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Scoreboard: every response pulse must match the oldest expectation.
  always @(negedge clk_bus) begin
    if (rsp_valid) begin
      if (sb_q.size() == 0) begin
        check("spurious_rsp_valid", 32'(rsp_valid), 32'd0);
      end else begin
        mon_e = sb_q.pop_front();
        check("sb_rsp_code", 32'(rsp_code), 32'(mon_e.code));
        check("sb_rsp_dat", rsp_dat, mon_e.dat);
      end
    end
  end

  task automatic clear_slave();
    wb.ack_i   = 1'b0;
    wb.err_i   = 1'b0;
    wb.rty_i   = 1'b0;
    wb.stall_i = 1'b0;
  endtask

  // One transfer. The slave stalls every strobe n_stall cycles, answers the
  // first n_rty WAIT cycles with rty_i, then terminates as 'term' says.
  // exp_lat > 0 checks the RESP cycle index counted from the acceptance edge.
  task automatic do_xfer(input string tag, input logic we, input logic [31:0] adr,
                         input logic [3:0] sel, input logic [31:0] dat, input int n_stall,
                         input int n_rty, input int term, input logic [31:0] rdata,
                         input int exp_lat);
    int retries, strobes, exp_wait, a_edge, r_edge, stall_left, rty_done;
    int stb_cyc, wait_cyc, gap_cyc, gap_evt, ns;
    bit done, prev_cyc, bus_bad, ready_bad, busy_bad, noise;
    logic [1:0]  e_code;
    logic [31:0] e_dat;
    retries = (n_rty > RMAX) ? RMAX : n_rty;
    strobes = retries + 1;
    if (n_rty > RMAX) begin
      e_code = 2'b10; e_dat = 32'h0; exp_wait = strobes;
    end else if (term == T_ERR || term == T_ERRACK) begin
      e_code = 2'b01; e_dat = 32'h0; exp_wait = strobes;
    end else if (term == T_NONE) begin
      e_code = 2'b11; e_dat = 32'h0; exp_wait = retries + TMO;
    end else begin
      e_code = 2'b00; e_dat = we ? 32'h0 : rdata; exp_wait = strobes;
    end
    noise = (n_stall > 0);
    @(negedge clk_bus);
    check({tag, "_ready"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_we = we; req_adr = adr; req_sel = sel; req_dat = dat;
    sb_q.push_back('{e_dat, e_code});
    a_edge = cyc_n + 1;
    r_edge = 0; stall_left = n_stall; rty_done = 0;
    stb_cyc = 0; wait_cyc = 0; gap_cyc = 0; gap_evt = 0; ns = 0;
    done = 1'b0; prev_cyc = 1'b1; bus_bad = 1'b0; ready_bad = 1'b0; busy_bad = 1'b0;
    while (!done && ns < 2000) begin
      @(negedge clk_bus);
      ns++;
      // Scramble the host inputs: the DUT must use its latched copy.
      req_valid = 1'b0; req_we = ~we; req_adr = ~adr; req_sel = ~sel; req_dat = ~dat;
      clear_slave();
      wb.dat_i = rdata;
      if (req_ready) ready_bad = 1'b1;
      if (wb.cyc_o && (wb.adr_o !== adr || wb.sel_o !== sel || wb.dat_o !== dat || wb.we_o !== we))
        bus_bad = 1'b1;
      if ((wb.cyc_o || rsp_valid) && !busy) busy_bad = 1'b1;
      if (rsp_valid) begin
        r_edge = cyc_n;
        done   = 1'b1;
        check({tag, "_cyc_in_resp"}, 32'(wb.cyc_o), 32'd0);
      end else if (wb.stb_o) begin
        stb_cyc++;
        wb.ack_i = noise;  // must be ignored outside WAIT
        if (stall_left > 0) begin
          wb.stall_i = 1'b1;
          stall_left--;
        end else begin
          stall_left = n_stall;
        end
      end else if (wb.cyc_o) begin
        wait_cyc++;
        if (rty_done < n_rty) begin
          wb.rty_i = 1'b1;
          rty_done++;
        end else if (term == T_ACK) begin
          wb.ack_i = 1'b1;
        end else if (term == T_ERR) begin
          wb.err_i = 1'b1;
        end else if (term == T_ERRACK) begin
          wb.err_i = 1'b1;
          wb.ack_i = 1'b1;
        end
      end else begin
        gap_cyc++;
        if (prev_cyc) gap_evt++;
      end
      prev_cyc = wb.cyc_o;
    end
    check({tag, "_completed"}, 32'(done), 32'd1);
    if (done) begin
      check({tag, "_stb_cycles"}, stb_cyc, strobes * (n_stall + 1));
      check({tag, "_wait_cycles"}, wait_cyc, exp_wait);
      check({tag, "_gap_cycles"}, gap_cyc, retries);
      check({tag, "_gap_events"}, gap_evt, retries);
      check({tag, "_bus_stable"}, 32'(bus_bad), 32'd0);
      check({tag, "_ready_low"}, 32'(ready_bad), 32'd0);
      check({tag, "_busy_high"}, 32'(busy_bad), 32'd0);
      if (exp_lat > 0) check({tag, "_latency"}, r_edge - a_edge + 1, exp_lat);
      @(negedge clk_bus);
      check({tag, "_pulse_one_cycle"}, 32'(rsp_valid), 32'd0);
      check({tag, "_ready_after"}, 32'(req_ready), 32'd1);
      check({tag, "_code_hold"}, 32'(rsp_code), 32'(e_code));
      check({tag, "_dat_hold"}, rsp_dat, e_dat);
    end
  endtask

  // Start a read, let it sit in WAIT, then pulse reset.
  task automatic reset_mid_wait();
    int ns;
    bit in_wait;
    @(negedge clk_bus);
    req_valid = 1'b1; req_we = 1'b0; req_adr = 32'h0000_0400; req_sel = 4'hF; req_dat = 32'h0;
    ns = 0; in_wait = 1'b0;
    while (!in_wait && ns < 20) begin
      @(negedge clk_bus);
      ns++;
      req_valid = 1'b0;
      in_wait = wb.cyc_o && !wb.stb_o;
    end
    check("rst_reached_wait", 32'(in_wait), 32'd1);
    repeat (3) @(negedge clk_bus);
    rst_bus = 1'b1;
    #1;
    check("rst_cyc_async", 32'(wb.cyc_o), 32'd0);
    check("rst_stb_async", 32'(wb.stb_o), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ready_low", 32'(req_ready), 32'd0);
    check("rst_no_rsp", 32'(rsp_valid), 32'd0);
    @(negedge clk_bus);
    rst_bus = 1'b0;
    #1;
    check("rst_ready_release", 32'(req_ready), 32'd1);
    repeat (4) @(negedge clk_bus);
    check("rst_stays_idle", 32'(busy), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_bus = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_adr = '0; req_sel = '0; req_dat = '0;
    wb.dat_i = '0;
    clear_slave();
    #2 rst_bus = 1'b1;
    repeat (3) @(negedge clk_bus);
    check("reset_ready", 32'(req_ready), 32'd0);
    check("reset_cyc", 32'(wb.cyc_o), 32'd0);
    check("reset_stb", 32'(wb.stb_o), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset_rsp_code", 32'(rsp_code), 32'd0);
    check("reset_rsp_dat", rsp_dat, 32'h0);
    check("reset_adr", wb.adr_o, 32'h0);
    rst_bus = 1'b0;
    #1;
    check("reset_release_ready", 32'(req_ready), 32'd1);

    // Terminations while IDLE must not start or end anything.
    @(negedge clk_bus);
    wb.ack_i = 1'b1; wb.err_i = 1'b1; wb.rty_i = 1'b1;
    repeat (2) @(negedge clk_bus);
    check("idle_term_busy", 32'(busy), 32'd0);
    check("idle_term_cyc", 32'(wb.cyc_o), 32'd0);
    clear_slave();

    do_xfer("rd_zero_wait", 1'b0, 32'h8000_0010, 4'hF, 32'h0, 0, 0, T_ACK, 32'hDEAD_BEEF, 3);
    do_xfer("wr_stall4", 1'b1, 32'h0000_2000, 4'h3, 32'h1234_5678, 4, 0, T_ACK, 32'hA5A5_A5A5, 0);
    do_xfer("rd_rty3_ack", 1'b0, 32'h0000_0100, 4'hF, 32'h0, 0, 3, T_ACK, 32'hCAFE_F00D, 0);
    do_xfer("wr_rty4_fail", 1'b1, 32'h0000_0104, 4'hC, 32'h5555_AAAA, 0, 4, T_ACK, 32'h1111_2222, 0);
    do_xfer("rd_timeout", 1'b0, 32'h0000_0200, 4'hF, 32'h0, 0, 0, T_NONE, 32'h7777_7777, 0);
    do_xfer("rd_err_ack", 1'b0, 32'h0000_0300, 4'hF, 32'h0, 0, 0, T_ERRACK, 32'h8888_9999, 0);
    do_xfer("wr_err", 1'b1, 32'h0000_0304, 4'h1, 32'hFFFF_0000, 1, 0, T_ERR, 32'h3333_4444, 0);
    do_xfer("rd_stall2_rty1", 1'b0, 32'h4000_0000, 4'hF, 32'h0, 2, 1, T_ACK, 32'h0BAD_CAFE, 0);

    reset_mid_wait();
    do_xfer("rd_after_reset", 1'b0, 32'h8000_0020, 4'hF, 32'h0, 0, 0, T_ACK, 32'h1357_9BDF, 3);

    check("scoreboard_drained", sb_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
